wire_sensor_debouncer: RTL
==========================

// Module: wire_sensor_debouncer
// PURPOSE
// Input conditioning stage directly upstream of the synchronization trigger logic.
// Takes the raw, asynchronous, contact-bouncing wire_sensor line and synchronizes it.
// Qualifies each level change by requiring a stable window before accepting it.
// Delivers a clean level, single-cycle rise/fall pulses and a bounce statistic to the trigger sequencer.
// PARAMETERS
// SYNC_STAGES      2    flip-flop synchronizer depth, >= 2
// DEBOUNCE_CYCLES  200  consecutive equal samples needed to accept a change (2 us @ 100 MHz), >= 1
// CNT_W            16   width of stability counter, 2**CNT_W > DEBOUNCE_CYCLES
// BOUNCE_W         8    width of bounce_count
// INIT_LEVEL       0    level assumed at reset (sensor idle state)
// PORTS
// clk           in   1         system clock (100 MHz nominal)
// rst           in   1         asynchronous, active-high reset
// enable        in   1         1 = qualify input; 0 = freeze outputs, abort qualification
// clear_stats   in   1         synchronous clear of bounce_count
// sensor_async  in   1         raw wire sensor, asynchronous to clk
// sensor_level  out  1         debounced level
// rise_pulse    out  1         one-cycle pulse when sensor_level goes 0->1
// fall_pulse    out  1         one-cycle pulse when sensor_level goes 1->0
// qualifying    out  1         1 while a candidate change is being timed
// bounce_count  out  BOUNCE_W  aborted qualifications since last clear, saturating
// BEHAVIOUR
// - Reset: sync chain = INIT_LEVEL, state = STABLE_LOW/HIGH per INIT_LEVEL, sensor_level = INIT_LEVEL.
// - Reset: rise/fall_pulse = 0, qualifying = 0, bounce_count = 0, cnt = 0.
// - s = last synchronizer stage; all decisions use s only.
// - FSM: STABLE_LOW, QUAL_HIGH, STABLE_HIGH, QUAL_LOW.
// - STABLE_LOW: s==1 -> QUAL_HIGH, cnt<=1. STABLE_HIGH: s==0 -> QUAL_LOW, cnt<=1.
// - QUAL_HIGH, s==0: -> STABLE_LOW, bounce_count++.
// - QUAL_HIGH, s==1, cnt==DEBOUNCE_CYCLES: -> STABLE_HIGH, sensor_level<=1, rise_pulse<=1.
// - QUAL_HIGH, s==1, cnt<DEBOUNCE_CYCLES: cnt++.
// - QUAL_LOW mirrors QUAL_HIGH, using fall_pulse and sensor_level<=0.
// - DEBOUNCE_CYCLES==1: the first sample entering QUAL already satisfies cnt==1.
// -   Accept occurs on the next edge, so minimum latency is 1 qualifying cycle.
// - Latency: sensor edge -> sensor_level/pulse = SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles.
// -   Tolerance +/-1 cycle due to asynchronous sampling.
// - Pulses are registered and exactly 1 cycle wide; never both high; never high while enable==0.
// - qualifying = 1 exactly in QUAL_HIGH/QUAL_LOW.
// - bounce_count saturates at all-ones, no wrap.
// - clear_stats coincident with an abort: clear wins, result 0.
// - enable==0: QUAL_* -> matching STABLE_* state, cnt<=0, no bounce increment.
// -   sensor_level holds; the synchronizer keeps running.
// -   On re-enable, a differing s starts a fresh qualification.
// - Reset mid-qualification: immediate return to reset values, no pulse emitted.
// - Glitch shorter than one clock may be missed entirely (acceptable by design).
// TESTING (clk 10 ns, defaults)
// - Reset release, sensor held 0 -> sensor_level=0, no pulses, bounce_count=0 for 1000 cycles.
// - Clean 0->1 step -> single rise_pulse 203 +/-1 cycles after the edge; sensor_level=1 thereafter.
// - 10 toggles at 100-1000 ns spacing, then held 1 -> exactly one rise_pulse ~2 us after the final edge.
// -   Same scenario: bounce_count = number of qualifications aborted, <=10; no fall_pulse.
// - High held 1990 ns then low: no rise_pulse, bounce_count+1.
// -   Repeat 255+ times -> bounce_count stays 255.
// - enable dropped 100 cycles into QUAL_HIGH, raised again with input still 1:
// -   qualifying clears, no pulse during disable, rise_pulse 201 +/-1 cycles after re-enable.
// - rst asserted mid-QUAL_LOW, abort and clear_stats on the same cycle:
// -   outputs return to reset values immediately; bounce_count reads 0.

Source files
------------

// File: rtl/wire_sensor_debouncer.sv
// wire_sensor_debouncer
// Synchronizes the raw wire-sensor line and accepts a level change only after
// the synchronized sample has stayed at the new value for DEBOUNCE_CYCLES
// consecutive clocks. Produces a clean level, one-cycle rise/fall pulses, a
// "qualifying" indicator and a saturating count of aborted qualifications.
module wire_sensor_debouncer #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 200,
  parameter int   CNT_W           = 16,
  parameter int   BOUNCE_W        = 8,
  parameter logic INIT_LEVEL      = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                clear_stats,
  input  logic                sensor_async,
  output logic                sensor_level,
  output logic                rise_pulse,
  output logic                fall_pulse,
  output logic                qualifying,
  output logic [BOUNCE_W-1:0] bounce_count
);

  typedef enum logic [1:0] {
    ST_STABLE_LOW,
    ST_QUAL_HIGH,
    ST_STABLE_HIGH,
    ST_QUAL_LOW
  } state_t;

  localparam logic [CNT_W-1:0]    DEB_TARGET = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [BOUNCE_W-1:0] BOUNCE_MAX = '1;
  localparam state_t              RST_STATE  = INIT_LEVEL ? ST_STABLE_HIGH : ST_STABLE_LOW;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;

  state_t                 r_state,  w_state_nxt;
  logic [CNT_W-1:0]       r_cnt,    w_cnt_nxt;
  logic                   r_level,  w_level_nxt;
  logic                   r_rise,   w_rise_nxt;
  logic                   r_fall,   w_fall_nxt;
  logic [BOUNCE_W-1:0]    r_bounce, w_bounce_nxt;
  logic                   w_abort;

  // Synchronizer chain: keeps running regardless of enable.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= {SYNC_STAGES{INIT_LEVEL}};
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], sensor_async};
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= RST_STATE;
      r_cnt    <= '0;
      r_level  <= INIT_LEVEL;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_bounce <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_level  <= w_level_nxt;
      r_rise   <= w_rise_nxt;
      r_fall   <= w_fall_nxt;
      r_bounce <= w_bounce_nxt;
    end
  end

  // Next-state, counter and pulse decisions, all from the last sync stage.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    w_abort     = 1'b0;

    unique case (r_state)
      ST_STABLE_LOW: begin
        if (enable && w_s) begin
          w_state_nxt = ST_QUAL_HIGH;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      ST_QUAL_HIGH: begin
        if (!enable) begin
          // Disable aborts silently: back to the level we still report.
          w_state_nxt = ST_STABLE_LOW;
          w_cnt_nxt   = '0;
        end else if (!w_s) begin
          w_state_nxt = ST_STABLE_LOW;
          w_cnt_nxt   = '0;
          w_abort     = 1'b1;
        end else if (r_cnt == DEB_TARGET) begin
          w_state_nxt = ST_STABLE_HIGH;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_STABLE_HIGH: begin
        if (enable && !w_s) begin
          w_state_nxt = ST_QUAL_LOW;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      ST_QUAL_LOW: begin
        if (!enable) begin
          w_state_nxt = ST_STABLE_HIGH;
          w_cnt_nxt   = '0;
        end else if (w_s) begin
          w_state_nxt = ST_STABLE_HIGH;
          w_cnt_nxt   = '0;
          w_abort     = 1'b1;
        end else if (r_cnt == DEB_TARGET) begin
          w_state_nxt = ST_STABLE_LOW;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = RST_STATE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Bounce statistic: clear has priority over a coincident abort; saturates.
  always_comb begin
    w_bounce_nxt = r_bounce;
    if (clear_stats)                         w_bounce_nxt = '0;
    else if (w_abort && r_bounce != BOUNCE_MAX) w_bounce_nxt = r_bounce + BOUNCE_W'(1);
  end

  assign sensor_level = r_level;
  // A pulse registered on the last enabled edge must not leak into a disabled cycle.
  assign rise_pulse   = r_rise & enable;
  assign fall_pulse   = r_fall & enable;
  assign qualifying   = (r_state == ST_QUAL_HIGH) || (r_state == ST_QUAL_LOW);
  assign bounce_count = r_bounce;

endmodule
